axil_req_scheduler: RTL and testbench

Sequences simple register-access requests from several internal requesters onto one AXI4-Lite master port that feeds the AXI-Lite crossbar's slave side. Requesters present a single-cycle command (address, write flag, data, strobes); the block arbitrates round-robin, runs exactly one AXI-Lite transaction at a time, and returns read data and response code to the granted requester. It is the only master on its crossbar port and never has more than one transaction outstanding.

---
 rtl/axil_sched_pkg.sv | 17 +
 rtl/axil_req_scheduler_if.sv | 37 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/axil_req_scheduler.sv | 137 +++++++++++++
 tb/tb_axil_req_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_sched_pkg.sv
// Shared types and constants for the AXI4-Lite request scheduler.
package axil_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_req_scheduler_if.sv
// AXI4-Lite bus between the scheduler (master) and the crossbar slave port.
interface axil_req_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter int NR   = 2,
  parameter int IDXW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic [NR-1:0]   req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NR-1:0]   grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any_req
);

  logic [IDXW:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NR; k++) begin
      cand = {1'b0, last_grant} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NR)) cand = cand - (IDXW+1)'(NR);
      if (grant == '0 && req[cand[IDXW-1:0]]) begin
        grant[cand[IDXW-1:0]] = 1'b1;
        grant_idx             = cand[IDXW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axil_req_scheduler.sv
// Round-robin scheduler funnelling NR single-cycle register requests onto one
// AXI4-Lite master port, one transaction in flight at a time.
module axil_req_scheduler #(
  parameter int NR         = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  input  logic [NR-1:0]                    REQ_VALID,
  output logic [NR-1:0]                    REQ_READY,
  input  logic [NR-1:0]                    REQ_WE,
  input  logic [NR-1:0][ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [NR-1:0][DATA_WIDTH-1:0]    REQ_WDATA,
  input  logic [NR-1:0][DATA_WIDTH/8-1:0]  REQ_WSTRB,
  output logic [NR-1:0]                    RSP_VALID,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic [1:0]                       RSP_RESP,
  axil_req_scheduler_if.master             M_AXI
);
  import axil_sched_pkg::*;

  localparam int IDXW = (NR > 1) ? $clog2(NR) : 1;
  localparam int SW   = DATA_WIDTH / 8;

  sched_state_e state, state_d;

  logic [IDXW-1:0]       last_grant, g_idx;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic [NR-1:0]   arb_grant;
  logic [IDXW-1:0] arb_idx;
  logic            arb_any;
  logic            load;
  logic            aw_pend_d, w_pend_d, resp_hs;

  rr_arbiter #(.NR(NR), .IDXW(IDXW)) u_arb (
    .req        (REQ_VALID),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  // AW and W retire independently; the phase ends once neither is pending.
  assign aw_pend_d = awvalid_q & ~M_AXI.AWREADY;
  assign w_pend_d  = wvalid_q  & ~M_AXI.WREADY;
  assign resp_hs   = we_q ? M_AXI.BVALID : M_AXI.RVALID;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    REQ_READY = '0;
    case (state)
      IDLE: if (S_AXI_ARESETN && arb_any) begin
        load      = 1'b1;
        REQ_READY = arb_grant;
        state_d   = ADDR;
      end
      ADDR: begin
        if (we_q) begin
          if (!aw_pend_d && !w_pend_d) state_d = RESP;
        end else if (arvalid_q && M_AXI.ARREADY) begin
          state_d = RESP;
        end
      end
      RESP:    if (resp_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      last_grant  <= IDXW'(NR-1);
      g_idx       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      if (load) begin
        g_idx     <= arb_idx;
        we_q      <= REQ_WE[arb_idx];
        addr_q    <= REQ_ADDR[arb_idx];
        wdata_q   <= REQ_WDATA[arb_idx];
        wstrb_q   <= REQ_WSTRB[arb_idx];
        awvalid_q <= REQ_WE[arb_idx];
        wvalid_q  <= REQ_WE[arb_idx];
        arvalid_q <= ~REQ_WE[arb_idx];
      end
      if (state == ADDR) begin
        awvalid_q <= aw_pend_d;
        wvalid_q  <= w_pend_d;
        arvalid_q <= arvalid_q & ~M_AXI.ARREADY;
      end
      if (state == RESP && resp_hs) begin
        rsp_resp_q  <= we_q ? M_AXI.BRESP : M_AXI.RRESP;
        rsp_rdata_q <= we_q ? '0 : M_AXI.RDATA;
      end
      if (state == DONE) last_grant <= g_idx;
    end
  end

  assign M_AXI.AWVALID = awvalid_q;
  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWPROT  = AXPROT_DEFAULT;
  assign M_AXI.WVALID  = wvalid_q;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = wstrb_q;
  assign M_AXI.ARVALID = arvalid_q;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARPROT  = AXPROT_DEFAULT;
  assign M_AXI.BREADY  = (state == RESP) &&  we_q;
  assign M_AXI.RREADY  = (state == RESP) && !we_q;

  assign RSP_VALID = (state == DONE) ? (NR'(1) << g_idx) : '0;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;

endmodule

// File: tb/tb_axil_req_scheduler.sv
// Directed bench for axil_req_scheduler: configurable AXI-Lite slave model plus
// a response scoreboard checked by an independent monitor.
module tb_axil_req_scheduler;
  import axil_sched_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic                     clk;
  logic                     S_AXI_ARESETN;
  logic [NR-1:0]            REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
  logic [NR-1:0][AW-1:0]    REQ_ADDR;
  logic [NR-1:0][DW-1:0]    REQ_WDATA;
  logic [NR-1:0][DW/8-1:0]  REQ_WSTRB;
  logic [DW-1:0]            RSP_RDATA;
  logic [1:0]               RSP_RESP;

  axil_req_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

  axil_req_scheduler #(.NR(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .REQ_VALID     (REQ_VALID),
    .REQ_READY     (REQ_READY),
    .REQ_WE        (REQ_WE),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_WDATA     (REQ_WDATA),
    .REQ_WSTRB     (REQ_WSTRB),
    .RSP_VALID     (RSP_VALID),
    .RSP_RDATA     (RSP_RDATA),
    .RSP_RESP      (RSP_RESP),
    .M_AXI         (m_axi)
  );

  int   tests = 0, fails = 0, cyc = 0, n_rsp = 0, rdy_cyc = 0;
  exp_t exp_q[$];

  // slave model configuration and bookkeeping
  int          aw_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  logic [31:0] rdata_cfg = '0;
  bit          rd_echo = 0;
  int          aw_cnt = 0, r_cnt = 0, aw_hs = 0, w_hs = 0, b_hs = 0, aw_only = 0;
  bit          have_aw = 0, have_w = 0, have_ar = 0, b_rdy_last = 0, r_rdy_last = 0;
  logic [31:0] last_awaddr = '0, last_araddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Slave: readies/valids decided at negedge; a ready or valid held across a
  // posedge together with its partner means that handshake completed there.
  initial begin
    m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.BVALID = 0; m_axi.BRESP = 0;
    m_axi.ARREADY = 0; m_axi.RVALID = 0; m_axi.RDATA = 0; m_axi.RRESP = 0;
    forever begin
      @(negedge clk);
      if (!S_AXI_ARESETN) begin
        m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.BVALID = 0; m_axi.ARREADY = 0;
        m_axi.RVALID = 0; m_axi.RDATA = 0;
        have_aw = 0; have_w = 0; have_ar = 0; aw_cnt = 0; r_cnt = 0;
        b_rdy_last = 0; r_rdy_last = 0;
      end else begin
        if (m_axi.AWREADY) begin aw_hs++; have_aw = 1; end
        if (m_axi.WREADY)  begin w_hs++;  have_w  = 1; end
        if (m_axi.ARREADY) have_ar = 1;
        if (m_axi.BVALID && b_rdy_last) begin b_hs++; m_axi.BVALID = 0; end
        if (m_axi.RVALID && r_rdy_last) begin m_axi.RVALID = 0; m_axi.RDATA = '0; end
        if (m_axi.AWVALID && !m_axi.WVALID) aw_only++;
        m_axi.AWREADY = m_axi.AWVALID && (aw_cnt >= aw_dly);
        if (m_axi.AWREADY) last_awaddr = m_axi.AWADDR;
        aw_cnt = m_axi.AWVALID ? aw_cnt + 1 : 0;
        m_axi.WREADY = m_axi.WVALID;
        if (m_axi.WREADY) begin last_wdata = m_axi.WDATA; last_wstrb = m_axi.WSTRB; end
        m_axi.ARREADY = m_axi.ARVALID;
        if (m_axi.ARREADY) last_araddr = m_axi.ARADDR;
        if (have_aw && have_w && !m_axi.BVALID) begin
          m_axi.BVALID = 1; m_axi.BRESP = bresp_cfg; have_aw = 0; have_w = 0;
        end
        if (have_ar && !m_axi.RVALID) begin
          if (r_cnt >= r_dly) begin
            m_axi.RVALID = 1; m_axi.RRESP = rresp_cfg; have_ar = 0; r_cnt = 0;
            m_axi.RDATA = rd_echo ? {16'hC0DE, last_araddr[15:0]} : rdata_cfg;
          end else r_cnt++;
        end
        b_rdy_last = m_axi.BREADY;
        r_rdy_last = m_axi.RREADY;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  initial begin
    exp_t e;
    logic [NR-1:0] ev;
    forever begin
      @(negedge clk); #1;
      if (|REQ_READY) rdy_cyc = cyc;
      if (|RSP_VALID) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("unexpected_rsp", 64'(RSP_VALID), 0);
        else begin
          e = exp_q.pop_front();
          ev = '0; ev[e.idx] = 1'b1;
          chk("rsp_valid_onehot", 64'(RSP_VALID), 64'(ev));
          chk("rsp_resp", 64'(RSP_RESP), 64'(e.resp));
          chk("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
          chk("rsp_latency", 64'(cyc - rdy_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic push(input int idx, input logic [1:0] resp, input logic [31:0] rd, input int lat);
    exp_t e;
    e.idx = idx; e.resp = resp; e.rdata = rd; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    REQ_WE[i] = we; REQ_ADDR[i] = a; REQ_WDATA[i] = d; REQ_WSTRB[i] = s; REQ_VALID[i] = 1'b1;
    #1;
    while (!REQ_READY[i] && n < 50) begin @(negedge clk); #1; n++; end
    if (!REQ_READY[i]) chk("issue_timeout", 0, 1);
    @(negedge clk);
    REQ_VALID[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (n_rsp < n && k < budget) begin @(negedge clk); #2; k++; end
    if (n_rsp < n) chk("rsp_timeout", 64'(n_rsp), 64'(n));
  endtask

  initial begin
    int k, got, aw0, w0, b0;
    S_AXI_ARESETN = 0;
    REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    repeat (3) @(negedge clk);
    REQ_VALID = 2'b01; #1;
    chk("rst_no_ready_in_reset", 64'(REQ_READY), 0);
    REQ_VALID = '0;
    chk("rst_axi_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID, m_axi.BREADY, m_axi.RREADY}, 0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 0);
    chk("rst_rsp_rdata", 64'(RSP_RDATA), 0);
    chk("rst_rsp_resp", 64'(RSP_RESP), 0);
    chk("rst_addr", {m_axi.AWADDR, m_axi.ARADDR}, 0);
    chk("rst_wdata_strb", {m_axi.WDATA, m_axi.WSTRB}, 0);
    chk("rst_prot", {m_axi.AWPROT, m_axi.ARPROT}, 0);
    @(negedge clk);
    S_AXI_ARESETN = 1;

    // single zero-wait write from requester 0
    push(0, RESP_OKAY, 32'h0, 3);
    issue(0, 1, 32'h0100_0004, 32'hDEAD_BEEF, 4'hF);
    chk("t1_aw_w_at_T1", {m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID}, 3'b110);
    wait_rsp(1, 20);
    chk("t1_awaddr", 64'(last_awaddr), 64'h0100_0004);
    chk("t1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
    chk("t1_wstrb", 64'(last_wstrb), 64'hF);

    // read with 5-cycle RVALID delay from requester 1
    r_dly = 5; rdata_cfg = 32'h1234_5678;
    push(1, RESP_OKAY, 32'h1234_5678, 8);
    issue(1, 0, 32'h0000_0040, 32'h0, 4'h0);
    wait_rsp(2, 40);
    chk("t2_araddr", 64'(last_araddr), 64'h40);
    r_dly = 0;

    // write where W handshakes three cycles ahead of AW
    aw_dly = 3; aw_only = 0; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    push(0, RESP_OKAY, 32'h0, 6);
    issue(0, 1, 32'h0100_0008, 32'hCAFE_F00D, 4'h3);
    wait_rsp(3, 40);
    repeat (3) @(negedge clk);
    chk("t3_aw_only_cycles", 64'(aw_only), 3);
    chk("t3_aw_hs", 64'(aw_hs - aw0), 1);
    chk("t3_w_hs", 64'(w_hs - w0), 1);
    chk("t3_b_hs_once", 64'(b_hs - b0), 1);
    chk("t3_wstrb", 64'(last_wstrb), 64'h3);
    aw_dly = 0;

    // DECERR on an unmapped read, data forwarded
    rresp_cfg = RESP_DECERR; rdata_cfg = 32'hDEC0_DE11;
    push(1, RESP_DECERR, 32'hDEC0_DE11, 3);
    issue(1, 0, 32'h0200_0000, 32'h0, 4'h0);
    wait_rsp(4, 20);
    chk("t4_araddr", 64'(last_araddr), 64'h0200_0000);
    rresp_cfg = RESP_OKAY;

    // both requesters held valid for six transactions
    rd_echo = 1;
    for (int t = 0; t < 6; t++)
      push(t % 2, RESP_OKAY, (t % 2) ? 32'hC0DE_0014 : 32'hC0DE_0010, 3);
    @(negedge clk);
    REQ_WE = '0; REQ_ADDR[0] = 32'h10; REQ_ADDR[1] = 32'h14; REQ_VALID = 2'b11;
    got = 0; k = 0;
    while (got < 6 && k < 100) begin
      @(negedge clk);
      if (|RSP_VALID) got++;
      k++;
    end
    REQ_VALID = '0;
    wait_rsp(10, 10);
    repeat (3) @(negedge clk);
    chk("t5_no_extra_grant", {m_axi.ARVALID, m_axi.RREADY}, 0);
    rd_echo = 0;

    // SLVERR on a write is forwarded untouched
    bresp_cfg = RESP_SLVERR;
    push(1, RESP_SLVERR, 32'h0, 3);
    issue(1, 1, 32'h0300_0000, 32'h1111_2222, 4'hF);
    wait_rsp(11, 20);
    bresp_cfg = RESP_OKAY;

    // reset while waiting in RESP
    r_dly = 30;
    issue(0, 0, 32'h50, 32'h0, 4'h0);
    k = 0;
    while (!m_axi.RREADY && k < 20) begin @(negedge clk); k++; end
    chk("t6_reached_resp", 64'(m_axi.RREADY), 1);
    S_AXI_ARESETN = 0;
    @(negedge clk);
    chk("t6_rst_axi_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID, m_axi.BREADY, m_axi.RREADY}, 0);
    chk("t6_rst_rsp_valid", 64'(RSP_VALID), 0);
    chk("t6_rst_req_ready", 64'(REQ_READY), 0);
    chk("t6_rst_rsp_resp", 64'(RSP_RESP), 0);
    chk("t6_rst_rsp_rdata", 64'(RSP_RDATA), 0);
    @(negedge clk);
    S_AXI_ARESETN = 1;
    r_dly = 0; rdata_cfg = 32'h0BAD_F00D;
    push(1, RESP_OKAY, 32'h0BAD_F00D, 3);
    issue(1, 0, 32'h60, 32'h0, 4'h0);
    wait_rsp(12, 20);
    chk("t6_post_reset_araddr", 64'(last_araddr), 64'h60);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    chk("total_responses", 64'(n_rsp), 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
